// File: rtl/processor_pkg.sv
// Shared types and constants for the processor register-file path.
package processor_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_INSTR,
    ST_GET_A,
    ST_GET_ADDR,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_GET_B
  } state_e;

  localparam logic [1:0] SEL_A     = 2'd0;
  localparam logic [1:0] SEL_B     = 2'd1;
  localparam logic [1:0] SEL_INSTR = 2'd2;
  localparam logic [1:0] SEL_BUF   = 2'd3;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory read; expired marks the last allowed wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // expired is high during the MEM_TIMEOUT-th counted cycle
  assign expired = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (count && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Loads instruction byte, register A (from user bus or data memory) and register B
// into the register file, producing the write-port controls.
module operand_loader
  import processor_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int MEM_TIMEOUT  = 15,
  parameter int MEM_FLAG_BIT = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              wr_en,
  output logic [1:0]        sel,
  output logic              src_mem,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  state_e            r_state;
  logic              r_wr_en, r_src_mem, r_mem_req, r_done, r_error;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_wr_data, r_mem_addr;

  state_e            w_next;
  logic              w_wr_en, w_src_mem, w_mem_req, w_done, w_error, w_addr_load;
  logic [1:0]        w_sel;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_hs, w_expired, w_tmr_clear, w_tmr_count;

  // Valid/ready: a byte transfers on a cycle where in_valid and in_ready are both
  // high at the rising edge; in_ready never depends on in_valid and drops under abort.
  assign in_ready  = !abort && (r_state == ST_GET_INSTR || r_state == ST_GET_A ||
                                r_state == ST_GET_ADDR  || r_state == ST_GET_B);
  assign w_hs      = in_valid && in_ready;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  assign w_tmr_clear = (r_state != ST_MEM_WAIT);
  assign w_tmr_count = (r_state == ST_MEM_WAIT);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (w_tmr_clear),
    .count   (w_tmr_count),
    .expired (w_expired)
  );

  always_comb begin
    w_next      = r_state;
    w_wr_en     = 1'b0;
    w_sel       = r_sel;
    w_src_mem   = r_src_mem;
    w_wr_data   = r_wr_data;
    w_mem_req   = 1'b0;
    w_addr_load = 1'b0;
    w_done      = 1'b0;
    w_error     = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_next = ST_GET_INSTR;
        ST_GET_INSTR: if (w_hs) begin
          w_wr_en   = 1'b1;
          w_sel     = SEL_INSTR;
          w_src_mem = 1'b0;
          w_wr_data = in_data;
          w_next    = in_data[MEM_FLAG_BIT] ? ST_GET_ADDR : ST_GET_A;
        end
        ST_GET_A: if (w_hs) begin
          w_wr_en   = 1'b1;
          w_sel     = SEL_A;
          w_src_mem = 1'b0;
          w_wr_data = in_data;
          w_next    = ST_GET_B;
        end
        ST_GET_ADDR: if (w_hs) begin
          // mem_req is registered, so raising it here makes it coincide with MEM_REQ
          w_addr_load = 1'b1;
          w_mem_req   = 1'b1;
          w_next      = ST_MEM_REQ;
        end
        ST_MEM_REQ: w_next = ST_MEM_WAIT;
        ST_MEM_WAIT: begin
          if (mem_rvalid) begin
            w_wr_en   = 1'b1;
            w_sel     = SEL_A;
            w_src_mem = 1'b1;
            w_wr_data = mem_rdata;
            w_next    = ST_GET_B;
          end else if (w_expired) begin
            w_error = 1'b1;
            w_next  = ST_IDLE;
          end
        end
        ST_GET_B: if (w_hs) begin
          w_wr_en   = 1'b1;
          w_sel     = SEL_B;
          w_src_mem = 1'b0;
          w_wr_data = in_data;
          w_done    = 1'b1;
          w_next    = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_wr_en    <= 1'b0;
      r_sel      <= SEL_A;
      r_src_mem  <= 1'b0;
      r_wr_data  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wr_en   <= w_wr_en;
      r_sel     <= w_sel;
      r_src_mem <= w_src_mem;
      r_wr_data <= w_wr_data;
      r_mem_req <= w_mem_req;
      r_done    <= w_done;
      r_error   <= w_error;
      if (w_addr_load) r_mem_addr <= in_data;
    end
  end

  assign wr_en    = r_wr_en;
  assign sel      = r_sel;
  assign src_mem  = r_src_mem;
  assign wr_data  = r_wr_data;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: expected register-file writes are queued from
// the load-order rules and checked against every write strobe.
module tb_operand_loader;

  logic       clock = 1'b0;
  logic       resetn, start, abort, in_valid, mem_rvalid;
  logic [7:0] in_data, mem_rdata;
  logic       in_ready, mem_req, wr_en, src_mem, busy, done, error;
  logic [7:0] mem_addr, wr_data;
  logic [1:0] sel;
  logic [2:0] dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int exp_err = 0;
  logic [11:0] exp_q[$];   // {done, src_mem, sel, data}
  logic [11:0] exp_e;

  operand_loader #(.DATA_W(8), .MEM_TIMEOUT(4), .MEM_FLAG_BIT(7)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .wr_en(wr_en), .sel(sel), .src_mem(src_mem),
    .wr_data(wr_data), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected writes of a complete sequence: instruction, A (bus or memory), B with done.
  task automatic model_seq(input logic [7:0] instr, input logic [7:0] a,
                           input logic [7:0] rdata, input logic [7:0] b);
    exp_q.push_back({1'b0, 1'b0, 2'd2, instr});
    if (instr[7]) exp_q.push_back({1'b0, 1'b1, 2'd0, rdata});
    else          exp_q.push_back({1'b0, 1'b0, 2'd0, a});
    exp_q.push_back({1'b1, 1'b0, 2'd1, b});
  endtask

  task automatic run_reg(input logic [7:0] i, input logic [7:0] a, input logic [7:0] b);
    model_seq(i, a, 8'h00, b);
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = i;
    tick();
    in_data = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("done_4_cycles_after_start", done, 1);
    tick();
    @(negedge clock);
    check("idle_after_done", busy, 0);
    check("done_single_pulse", done, 0);
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (wr_en) begin
        check("write_was_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("write_fields", {done, src_mem, sel, wr_data}, exp_e);
        end
      end
      check("done_without_write", done & ~wr_en, 0);
      if (error) begin
        check("error_was_expected", (exp_err > 0), 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; in_data = '0; in_valid = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    check("rst_wr_en", wr_en, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_src_mem", src_mem, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_state_idle", dbg_state, 0);
    @(negedge clock);
    resetn = 1'b1;
    tick();

    // register source, model pinned against hand-computed words
    model_seq(8'h12, 8'h34, 8'h00, 8'h56);
    check("model_instr_word", exp_q[0], 12'h212);
    check("model_a_word", exp_q[1], 12'h034);
    check("model_b_word", exp_q[2], 12'h956);
    exp_q.delete();
    run_reg(8'h12, 8'h34, 8'h56);

    // memory source, rvalid three cycles after mem_req
    tick();
    model_seq(8'h85, 8'h00, 8'hAB, 8'h01);
    check("model_mem_a_word", exp_q[1], 12'h4AB);
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h85;
    tick();
    in_data = 8'h20;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("mem_req_high", mem_req, 1);
    check("mem_addr_latched", mem_addr, 8'h20);
    tick();
    @(negedge clock);
    check("mem_req_one_cycle", mem_req, 0);
    check("mem_addr_held", mem_addr, 8'h20);
    check("no_ready_in_wait", in_ready, 0);
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'hAB;
    tick();
    mem_rvalid = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    @(negedge clock);
    check("mem_write_src", src_mem & wr_en, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("mem_seq_done", done, 1);

    // timeout: four wait cycles without rvalid
    tick();
    exp_q.push_back({1'b0, 1'b0, 2'd2, 8'h80});
    exp_err++;
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h80;
    tick();
    in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    check("no_early_error", error, 0);
    tick();
    @(negedge clock);
    check("timeout_error", error, 1);
    check("timeout_idle", busy, 0);
    check("timeout_no_write", wr_en, 0);
    tick();
    @(negedge clock);
    check("error_single_pulse", error, 0);

    // back-pressure: valid 0,1,0,1 from GET_A onwards
    tick();
    model_seq(8'h05, 8'h77, 8'h00, 8'h99);
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    tick();
    in_valid = 1'b0; in_data = 8'h77;
    @(negedge clock);
    check("ready_in_get_a", in_ready, 1);
    tick();
    in_valid = 1'b1;
    @(negedge clock);
    check("no_write_while_invalid", wr_en, 0);
    tick();
    in_valid = 1'b0; in_data = 8'h99;
    tick();
    in_valid = 1'b1;
    @(negedge clock);
    check("no_write_b_invalid", wr_en, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_done", done, 1);

    // abort together with the B handshake
    tick();
    exp_q.push_back({1'b0, 1'b0, 2'd2, 8'h11});
    exp_q.push_back({1'b0, 1'b0, 2'd0, 8'h22});
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_data = 8'h33; abort = 1'b1;
    @(negedge clock);
    check("abort_drops_ready", in_ready, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("abort_no_write", wr_en, 0);
    check("abort_no_done", done, 0);
    check("abort_idle", busy, 0);
    tick();
    run_reg(8'h31, 8'hB2, 8'hC3);

    // start and abort together in IDLE
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    check("start_abort_stays_idle", busy, 0);

    // reset in MEM_WAIT, then a stray rvalid
    tick();
    exp_q.push_back({1'b0, 1'b0, 2'd2, 8'h90});
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h90;
    tick();
    in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_mem_addr", mem_addr, 0);
    check("async_rst_sel", sel, 0);
    check("async_rst_wr_data", wr_data, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_mem_req", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 8'h5A;
    @(negedge clock);
    resetn = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b0;
    @(negedge clock);
    check("stray_rvalid_no_write", wr_en, 0);
    tick();

    check("exp_q_drained", exp_q.size(), 0);
    check("errors_all_seen", exp_err, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
